table_loader_2port: RTL and testbench

TABLE_LOADER_2PORT -- requirements
Module: table_loader_2port

---
 rtl/table_loader_2port.sv | 138 +++++++++++++
 tb/tb_table_loader_2port.sv | 248 ++++++++++++++++++++++++
 2 files changed

// File: rtl/table_loader_2port.sv
// Streamed table loader into a 2**AWIDTH x DWIDTH memory with two registered read ports.
// Optional macro TABLE_LOADER_WR_FWD_EN: a read hitting the address being written returns the new word.
module table_loader_2port #(
    parameter int unsigned DWIDTH = 8,
    parameter int unsigned AWIDTH = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [AWIDTH-1:0] base_addr,
    input  logic [AWIDTH:0]   count,
    input  logic [DWIDTH-1:0] s_data,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [AWIDTH-1:0] address_a,
    input  logic [AWIDTH-1:0] address_b,
    output logic [DWIDTH-1:0] qa,
    output logic [DWIDTH-1:0] qb,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned CWIDTH = AWIDTH + 1;
    localparam int unsigned DEPTH  = 1 << AWIDTH;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] LOAD = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [AWIDTH-1:0] wr_addr;
    logic [AWIDTH-1:0] wr_addr_nxt;
    logic [CWIDTH-1:0] remaining;
    logic [CWIDTH-1:0] remaining_nxt;
    logic              beat;
    logic              s_ready_nxt;
    logic              busy_nxt;
    logic              done_nxt;
    logic              err_nxt;
    logic [DWIDTH-1:0] qa_nxt;
    logic [DWIDTH-1:0] qb_nxt;

    logic [DWIDTH-1:0] mem [DEPTH];

    assign beat = (state == LOAD) && s_valid;

    // Next-state, load bookkeeping and registered-output values
    always_comb begin
        state_nxt     = state;
        wr_addr_nxt   = wr_addr;
        remaining_nxt = remaining;
        case (state)
            IDLE: begin
                if (start) begin
                    if (count == '0) begin
                        state_nxt = DONE;
                    end else begin
                        wr_addr_nxt   = base_addr;
                        remaining_nxt = count;
                        state_nxt     = LOAD;
                    end
                end
            end
            LOAD: begin
                if (beat) begin
                    wr_addr_nxt   = wr_addr + AWIDTH'(1);
                    remaining_nxt = remaining - CWIDTH'(1);
                    if (remaining == CWIDTH'(1)) begin
                        state_nxt = DONE;
                    end
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        // Status flags are registered from the next state so they track the state exactly
        s_ready_nxt = (state_nxt == LOAD);
        busy_nxt    = (state_nxt != IDLE);
        done_nxt    = (state_nxt == DONE);
        // A rejected start is reported on the cycle after it is sampled
        err_nxt     = start && (state != IDLE);

`ifdef TABLE_LOADER_WR_FWD_EN
        qa_nxt = (beat && (address_a == wr_addr)) ? s_data : mem[address_a];
        qb_nxt = (beat && (address_b == wr_addr)) ? s_data : mem[address_b];
`else
        qa_nxt = mem[address_a];
        qb_nxt = mem[address_b];
`endif
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Load pointer, counter and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr   <= '0;
            remaining <= '0;
            s_ready   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
            qa        <= '0;
            qb        <= '0;
        end else begin
            wr_addr   <= wr_addr_nxt;
            remaining <= remaining_nxt;
            s_ready   <= s_ready_nxt;
            busy      <= busy_nxt;
            done      <= done_nxt;
            err       <= err_nxt;
            qa        <= qa_nxt;
            qb        <= qb_nxt;
        end
    end

    // Table storage keeps its contents through reset
    always_ff @(posedge clk) begin
        if (beat) begin
            mem[wr_addr] <= s_data;
        end
    end

endmodule

// File: tb/tb_table_loader_2port.sv
// Directed + randomized bench for table_loader_2port against an array model of the table.
module tb_table_loader_2port;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 8;
    localparam int unsigned CW    = AW + 1;
    localparam int unsigned DEPTH = 1 << AW;
`ifdef TABLE_LOADER_WR_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    typedef logic [DW-1:0] dq_t[$];

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] base_addr = '0;
    logic [AW:0]   count = '0;
    logic [DW-1:0] s_data = '0;
    logic          s_valid = 1'b0;
    logic          s_ready;
    logic [AW-1:0] address_a = '0;
    logic [AW-1:0] address_b = '0;
    logic [DW-1:0] qa;
    logic [DW-1:0] qb;
    logic          busy;
    logic          done;
    logic          err;

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] ref_mem [DEPTH];
    bit rd_known = 1'b0;

    table_loader_2port #(.DWIDTH(DW), .AWIDTH(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .base_addr(base_addr), .count(count),
        .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .address_a(address_a), .address_b(address_b), .qa(qa), .qb(qb),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic read_check(input logic [AW-1:0] a, input logic [AW-1:0] b);
        address_a = a;
        address_b = b;
        step();
        chk("read_qa", 32'(qa), 32'(ref_mem[a]));
        chk("read_qb", 32'(qb), 32'(ref_mem[b]));
    endtask

    // Load n words from base; model: word i lands at (base+i) mod DEPTH
    task automatic load(input logic [AW-1:0] base, input int n, input dq_t d,
                        input int max_gap, input bit inj_err);
        logic [AW-1:0] wa;
        logic [AW-1:0] ra;
        logic [AW-1:0] rb;
        logic [DW-1:0] exp_a;
        logic [DW-1:0] exp_b;
        int gaps;
        start     = 1'b1;
        base_addr = base;
        count     = CW'(n);
        step();
        start = 1'b0;
        if (n == 0) begin
            chk("zero_done", 32'(done), 32'd1);
            chk("zero_busy", 32'(busy), 32'd1);
            chk("zero_ready", 32'(s_ready), 32'd0);
            step();
            chk("zero_done_end", 32'(done), 32'd0);
            chk("zero_busy_end", 32'(busy), 32'd0);
            chk("zero_ready_end", 32'(s_ready), 32'd0);
            return;
        end
        chk("load_ready", 32'(s_ready), 32'd1);
        chk("load_busy", 32'(busy), 32'd1);
        chk("load_done_low", 32'(done), 32'd0);
        wa = base;
        for (int i = 0; i < n; i++) begin
            gaps = (max_gap > 0) ? int'($urandom_range(0, max_gap)) : 0;
            for (int g = 0; g < gaps; g++) begin
                s_valid   = 1'b0;
                s_data    = DW'($urandom);
                ra        = AW'($urandom);
                address_a = ra;
                step();
                chk("gap_ready", 32'(s_ready), 32'd1);
                chk("gap_done", 32'(done), 32'd0);
                if (rd_known) chk("gap_qa", 32'(qa), 32'(ref_mem[ra]));
            end
            if (inj_err && i == 1) begin
                s_valid   = 1'b0;
                start     = 1'b1;
                base_addr = AW'($urandom);
                count     = CW'($urandom_range(1, DEPTH));
                step();
                start = 1'b0;
                chk("err_pulse", 32'(err), 32'd1);
                chk("err_ready", 32'(s_ready), 32'd1);
                step();
                chk("err_clear", 32'(err), 32'd0);
            end
            s_valid   = 1'b1;
            s_data    = d[i];
            address_a = wa;
            rb        = AW'($urandom);
            address_b = rb;
            exp_a = FWD ? d[i] : ref_mem[wa];
            exp_b = (FWD && rb == wa) ? d[i] : ref_mem[rb];
            step();
            s_valid = 1'b0;
            if (rd_known) begin
                chk("beat_qa", 32'(qa), 32'(exp_a));
                chk("beat_qb", 32'(qb), 32'(exp_b));
            end
            ref_mem[wa] = d[i];
            wa = wa + AW'(1);
            if (i < n - 1) begin
                chk("beat_ready", 32'(s_ready), 32'd1);
            end else begin
                chk("last_done", 32'(done), 32'd1);
                chk("last_ready", 32'(s_ready), 32'd0);
                chk("last_busy", 32'(busy), 32'd1);
            end
        end
        step();
        chk("end_done", 32'(done), 32'd0);
        chk("end_busy", 32'(busy), 32'd0);
        chk("end_err", 32'(err), 32'd0);
    endtask

    initial begin
        dq_t q;
        logic [AW-1:0] b;
        int n;

        // Reset values
        #2;
        chk("rst_ready", 32'(s_ready), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        chk("rst_qa", 32'(qa), 32'd0);
        chk("rst_qb", 32'(qb), 32'd0);
        step();
        rst_n = 1'b1;
        step();

        // Fill the whole table so every later read has a known value
        q = {};
        for (int i = 0; i < int'(DEPTH); i++) q.push_back(DW'($urandom));
        load(AW'(0), DEPTH, q, 0, 1'b0);
        rd_known = 1'b1;
        for (int i = 0; i < 4; i++) read_check(AW'($urandom), AW'($urandom));

        // Back-to-back load at 0x10
        q = {8'hA1, 8'hA2, 8'hA3, 8'hA4};
        load(8'h10, 4, q, 0, 1'b0);
        for (int i = 0; i < 4; i++) read_check(AW'(8'h10 + i), AW'($urandom));
        chk("tbl_0x13", 32'(ref_mem[8'h13]), 32'h0000_00A4);

        // Address wrap at the top of the table
        q = {8'h11, 8'h22, 8'h33};
        load(8'hFE, 3, q, 0, 1'b0);
        read_check(8'hFE, 8'hFF);
        read_check(8'h00, 8'hFD);

        // Zero-length load
        load(AW'($urandom), 0, q, 0, 1'b0);
        read_check(8'h10, 8'h00);

        // Rejected start during a gappy two-word load
        q = {DW'($urandom), DW'($urandom)};
        b = AW'($urandom);
        load(b, 2, q, 2, 1'b1);
        read_check(b, b + AW'(1));

        // Read/write collision: 0x00 then 0x5A at the same address
        q = {8'h00};
        load(8'h40, 1, q, 0, 1'b0);
        q = {8'h5A};
        load(8'h40, 1, q, 0, 1'b0);
        read_check(8'h40, 8'h41);

        // Reset after 2 of 4 beats
        start = 1'b1; base_addr = 8'h30; count = CW'(4);
        step();
        start = 1'b0;
        s_valid = 1'b1; s_data = 8'hB1; step();
        s_valid = 1'b1; s_data = 8'hB2; step();
        ref_mem[8'h30] = 8'hB1;
        ref_mem[8'h31] = 8'hB2;
        s_data = 8'hB3;
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", 32'(s_ready), 32'd0);
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_done", 32'(done), 32'd0);
        chk("mid_rst_qa", 32'(qa), 32'd0);
        chk("mid_rst_qb", 32'(qb), 32'd0);
        step();
        s_valid = 1'b0;
        chk("mid_rst_no_done", 32'(done), 32'd0);
        rst_n = 1'b1;
        step();
        chk("post_rst_done", 32'(done), 32'd0);
        chk("post_rst_busy", 32'(busy), 32'd0);
        read_check(8'h30, 8'h31);
        read_check(8'h32, 8'h33);

        // Random loads with valid gaps
        for (int t = 0; t < 8; t++) begin
            n = int'($urandom_range(1, 20));
            q = {};
            for (int i = 0; i < n; i++) q.push_back(DW'($urandom));
            b = AW'($urandom);
            load(b, n, q, 2, (t % 3) == 0);
            for (int i = 0; i < 3; i++) read_check(b + AW'($urandom_range(0, n - 1)), AW'($urandom));
        end

        // Full-table load from a nonzero base wraps to base-1
        q = {};
        for (int i = 0; i < int'(DEPTH); i++) q.push_back(DW'($urandom));
        load(8'h80, DEPTH, q, 1, 1'b0);
        read_check(8'h80, 8'h7F);
        read_check(8'hFF, 8'h00);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
